// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-granular memory copy engine.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } copyState_e;

   localparam int WORD_BYTES_DEFAULT = 4;

endpackage

// File: rtl/mem_copy_csum.sv
// Running XOR of every word the copy engine writes; cleared when a copy is accepted.
module mem_copy_csum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accumulate,
   input  logic [31:0] word,
   output logic [31:0] checksum
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         checksum <= '0;
      end else if (accumulate) begin
         checksum <= checksum ^ word;
      end
   end

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternating READ/WRITE cycles against a combinational-read memory.
// Optional checksum output is enabled with `define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int LEN_W      = 16,
   parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      memoryOutData,
   output logic             memoryRead,
   output logic             memoryWrite,
   output logic [31:0]      memoryAddress,
   output logic [31:0]      memoryWriteData,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done
`ifdef MEM_COPY_CHECKSUM_EN
   ,
   output logic [31:0]      checksum
`endif
);

   localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

   copyState_e       state;
   logic [31:0]      srcPtr;
   logic [31:0]      dstPtr;
   logic [31:0]      dataReg;
   logic [LEN_W-1:0] remaining;

   // Strobes, address, busy and done are registered so they change together with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         srcPtr        <= '0;
         dstPtr        <= '0;
         dataReg       <= '0;
         remaining     <= '0;
         words_done    <= '0;
         memoryRead    <= 1'b0;
         memoryWrite   <= 1'b0;
         memoryAddress <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  srcPtr     <= src_addr & ~32'h3;
                  dstPtr     <= dst_addr & ~32'h3;
                  remaining  <= len;
                  words_done <= '0;
                  busy       <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state         <= READ;
                     memoryRead    <= 1'b1;
                     memoryAddress <= src_addr & ~32'h3;
                  end
               end
            end
            READ: begin
               dataReg       <= memoryOutData;
               memoryRead    <= 1'b0;
               memoryWrite   <= 1'b1;
               memoryAddress <= dstPtr;
               state         <= WRITE;
            end
            WRITE: begin
               srcPtr      <= srcPtr + STRIDE;
               dstPtr      <= dstPtr + STRIDE;
               remaining   <= remaining - LEN_W'(1);
               words_done  <= words_done + LEN_W'(1);
               memoryWrite <= 1'b0;
               if (remaining == LEN_W'(1)) begin
                  state         <= DONE;
                  done          <= 1'b1;
                  memoryAddress <= '0;
               end else begin
                  state         <= READ;
                  memoryRead    <= 1'b1;
                  memoryAddress <= srcPtr + STRIDE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign memoryWriteData = (state == WRITE) ? dataReg : '0;

`ifdef MEM_COPY_CHECKSUM_EN
   mem_copy_csum csumInst (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == IDLE && start),
      .accumulate(state == WRITE),
      .word      (dataReg),
      .checksum  (checksum)
   );
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: 256-word aliased memory, array-level copy model, per-scenario tasks.
// Define MEM_COPY_CHECKSUM_EN to also exercise the checksum output.
module tb_mem_copy_engine;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] len;
   logic [31:0]      memoryOutData;
   logic             memoryRead;
   logic             memoryWrite;
   logic [31:0]      memoryAddress;
   logic [31:0]      memoryWriteData;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] words_done;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [31:0]      checksum;
   logic [31:0]      exp_csum;
`endif

   logic [31:0] mem     [0:255];
   logic [31:0] exp_mem [0:255];
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] rd_addr_q[$];
   int done_cnt;
   int both_total;
   int idle_bad;
   int total;
   int bad;

   mem_copy_engine #(.LEN_W(LEN_W), .WORD_BYTES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .len            (len),
      .memoryOutData  (memoryOutData),
      .memoryRead     (memoryRead),
      .memoryWrite    (memoryWrite),
      .memoryAddress  (memoryAddress),
      .memoryWriteData(memoryWriteData),
      .busy           (busy),
      .done           (done),
      .words_done     (words_done)
`ifdef MEM_COPY_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   function automatic logic [7:0] widx(input logic [31:0] a);
      return 8'(a >> 2);
   endfunction

   assign memoryOutData = mem[widx(memoryAddress)];

   // Memory write port and bus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (memoryWrite === 1'b1) begin
         mem[widx(memoryAddress)] = memoryWriteData;
         wr_addr_q.push_back(memoryAddress);
         wr_data_q.push_back(memoryWriteData);
      end
      if (memoryRead === 1'b1) rd_addr_q.push_back(memoryAddress);
      if (memoryRead === 1'b1 && memoryWrite === 1'b1) both_total++;
      if (done === 1'b1) done_cnt++;
      if (rst === 1'b0 && busy === 1'b0 &&
          (memoryRead !== 1'b0 || memoryWrite !== 1'b0 || memoryAddress !== 32'h0 ||
           memoryWriteData !== 32'h0 || done !== 1'b0))
         idle_bad++;
   end

   // ---------------- reference model ----------------
   task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s;
      logic [31:0] d;
      s = src & ~32'h3;
      d = dst & ~32'h3;
      for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
      exp_q.delete();
      exp_addr_q.delete();
`ifdef MEM_COPY_CHECKSUM_EN
      exp_csum = 32'h0;
`endif
      for (int i = 0; i < n; i++) begin
         exp_mem[widx(d)] = exp_mem[widx(s)];
         exp_q.push_back(exp_mem[widx(d)]);
         exp_addr_q.push_back(d);
`ifdef MEM_COPY_CHECKSUM_EN
         exp_csum = exp_csum ^ exp_mem[widx(d)];
`endif
         s = s + 32'd4;
         d = d + 32'd4;
      end
   endtask

   // ---------------- driver ----------------
   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input logic [LEN_W-1:0] n);
      @(negedge clk);
      src_addr = src;
      dst_addr = dst;
      len      = n;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_addr = $urandom;
      dst_addr = $urandom;
      len      = LEN_W'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      while (cyc < 300 && !got) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) got = 1'b1;
      end
      #1;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL done_timeout: no done within %0d cycles, required one", cyc);
      end
   endtask

   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [LEN_W-1:0] n,
                           output int cyc);
      clear_logs();
      pulse_start(src, dst, n);
      wait_done(cyc);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      src_addr = 32'h40;
      dst_addr = 32'h80;
      len = 16'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({memoryRead, memoryWrite, busy, done} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_strobes: rd/wr/busy/done=%b required 0000", {memoryRead, memoryWrite, busy, done});
      end
      total++;
      if (memoryAddress !== 32'h0 || memoryWriteData !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus: addr=%h wdata=%h required 0", memoryAddress, memoryWriteData);
      end
      total++;
      if (words_done !== '0) begin
         bad++;
         $display("FAIL reset_words_done: got %0d required 0", words_done);
      end
`ifdef MEM_COPY_CHECKSUM_EN
      total++;
      if (checksum !== 32'h0) begin
         bad++;
         $display("FAIL reset_checksum: got %h required 0", checksum);
      end
`endif
      start = 1'b0;
      rst   = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_after: busy=%b required 0", busy);
      end
   endtask

   task automatic test_basic();
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      mem[3] = 32'h44;
      run_copy(32'h0, 32'h40, 16'd4, cyc);
      total++;
      if (cyc !== 9) begin
         bad++;
         $display("FAIL basic_latency: done at cycle %0d required 9", cyc);
      end
      total++;
      if (words_done !== 16'd4) begin
         bad++;
         $display("FAIL basic_words_done: got %0d required 4", words_done);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[16+i] !== 32'h11 * 32'(i + 1)) begin
            bad++;
            $display("FAIL basic_dst_word%0d: got %h required %h", i, mem[16+i], 32'h11 * 32'(i + 1));
         end
      end
      total++;
      if (done_cnt !== 1 || wr_addr_q.size() !== 4 || rd_addr_q.size() !== 4) begin
         bad++;
         $display("FAIL basic_counts: done=%0d writes=%0d reads=%0d required 1/4/4",
                  done_cnt, wr_addr_q.size(), rd_addr_q.size());
      end
   endtask

   task automatic test_zero_length();
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_copy(32'h10, 32'h90, 0);
      run_copy(32'h10, 32'h90, 16'd0, cyc);
      total++;
      if (cyc !== 1) begin
         bad++;
         $display("FAIL zero_latency: done at cycle %0d required 1", cyc);
      end
      total++;
      if (rd_addr_q.size() !== 0 || wr_addr_q.size() !== 0) begin
         bad++;
         $display("FAIL zero_strobes: reads=%0d writes=%0d required 0/0", rd_addr_q.size(), wr_addr_q.size());
      end
      total++;
      if (words_done !== '0) begin
         bad++;
         $display("FAIL zero_words_done: got %0d required 0", words_done);
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      bit got;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_copy(32'h200, 32'h300, 3);
      clear_logs();
      pulse_start(32'h200, 32'h300, 16'd3);
      cyc = 0;
      got = 1'b0;
      while (cyc < 60 && !got) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) got = 1'b1;
         start    = (cyc >= 2 && cyc <= 5);
         src_addr = 32'h3C0;
         dst_addr = 32'h380;
         len      = 16'd7;
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (!got || cyc !== 7) begin
         bad++;
         $display("FAIL busy_latency: done seen=%0d at cycle %0d required 1 at 7", got, cyc);
      end
      total++;
      if (wr_addr_q.size() !== 3 || done_cnt !== 1) begin
         bad++;
         $display("FAIL busy_ignored: writes=%0d done pulses=%0d required 3/1", wr_addr_q.size(), done_cnt);
      end
      total++;
      if (mem[widx(32'h300)] !== exp_mem[widx(32'h300)] || mem[widx(32'h308)] !== exp_mem[widx(32'h308)]) begin
         bad++;
         $display("FAIL busy_data: got %h %h required %h %h", mem[widx(32'h300)], mem[widx(32'h308)],
                  exp_mem[widx(32'h300)], exp_mem[widx(32'h308)]);
      end
   endtask

   task automatic test_reset_mid_copy();
      int modified;
      for (int i = 0; i < 256; i++) mem[i] = 32'h5A000000 | 32'(i);
      clear_logs();
      pulse_start(32'h80, 32'h100, 16'd5);
      repeat (4) @(negedge clk);
      total++;
      if (memoryWrite !== 1'b1 || memoryAddress !== 32'h104) begin
         bad++;
         $display("FAIL rstmid_in_write2: wr=%b addr=%h required 1/00000104", memoryWrite, memoryAddress);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({memoryRead, memoryWrite, busy, done} !== 4'b0000 || memoryAddress !== 32'h0 ||
          memoryWriteData !== 32'h0 || words_done !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs: rd/wr/busy/done=%b addr=%h wdata=%h wd=%0d required all 0",
                  {memoryRead, memoryWrite, busy, done}, memoryAddress, memoryWriteData, words_done);
      end
      repeat (5) @(negedge clk);
      #1;
      modified = 0;
      for (int i = 64; i < 69; i++) if (mem[i] !== (32'h5A000000 | 32'(i))) modified++;
      total++;
      if (modified < 1 || modified > 2) begin
         bad++;
         $display("FAIL rstmid_modified: %0d dst words changed required 1 or 2", modified);
      end
      total++;
      if (done_cnt !== 0 || rd_addr_q.size() !== 2) begin
         bad++;
         $display("FAIL rstmid_abort: done pulses=%0d reads=%0d required 0/2", done_cnt, rd_addr_q.size());
      end
   endtask

   task automatic test_misalign_wrap();
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_copy(32'h3, 32'hFFFFFFFC, 2);
      run_copy(32'h3, 32'hFFFFFFFC, 16'd2, cyc);
      total++;
      if (rd_addr_q.size() !== 2 || rd_addr_q[0] !== 32'h0) begin
         bad++;
         $display("FAIL wrap_first_read: count=%0d addr=%h required 2/00000000", rd_addr_q.size(),
                  (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hX);
      end
      total++;
      if (wr_addr_q.size() !== 2 || wr_addr_q[0] !== 32'hFFFFFFFC || wr_addr_q[1] !== 32'h0) begin
         bad++;
         $display("FAIL wrap_write_addrs: count=%0d required 2 at fffffffc,00000000", wr_addr_q.size());
      end
      total++;
      if (wr_data_q.size() !== 2 || wr_data_q[0] !== exp_q[0] || wr_data_q[1] !== exp_q[1]) begin
         bad++;
         $display("FAIL wrap_write_data: count=%0d required %h,%h", wr_data_q.size(), exp_q[0], exp_q[1]);
      end
   endtask

   task automatic test_overlap();
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = 32'h70000000 | 32'(i);
      run_copy(32'h0, 32'h4, 16'd4, cyc);
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (mem[i] !== 32'h70000000) begin
            bad++;
            $display("FAIL overlap_word%0d: got %h required 70000000", i, mem[i]);
         end
      end
   endtask

   task automatic test_random();
      int cyc;
      int n;
      int diffs;
      logic [31:0] s;
      logic [31:0] d;
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 256; i++) mem[i] = $urandom;
         n = $urandom_range(0, 10);
         s = 32'($urandom_range(0, 32'h3FF));
         d = 32'($urandom_range(0, 32'h3FF));
         model_copy(s, d, n);
         run_copy(s, d, LEN_W'(n), cyc);
         total++;
         if (cyc !== ((n == 0) ? 1 : 2 * n + 1) || words_done !== LEN_W'(n)) begin
            bad++;
            $display("FAIL rand%0d_timing: cycle=%0d words_done=%0d required %0d/%0d", it, cyc, words_done,
                     (n == 0) ? 1 : 2 * n + 1, n);
         end
         diffs = 0;
         if (wr_data_q.size() != exp_q.size()) diffs++;
         else
            for (int k = 0; k < exp_q.size(); k++)
               if (wr_data_q[k] !== exp_q[k] || wr_addr_q[k] !== exp_addr_q[k]) diffs++;
         for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
         total++;
         if (diffs != 0) begin
            bad++;
            $display("FAIL rand%0d_data: %0d differences vs model (src=%h dst=%h len=%0d) required 0",
                     it, diffs, s, d, n);
         end
`ifdef MEM_COPY_CHECKSUM_EN
         total++;
         if (checksum !== exp_csum) begin
            bad++;
            $display("FAIL rand%0d_checksum: got %h required %h", it, checksum, exp_csum);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      int cyc1;
      int cyc2;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      run_copy(32'h20, 32'h2A0, 16'd2, cyc1);
      model_copy(32'h2A0, 32'h1F0, 2);
      run_copy(32'h2A0, 32'h1F0, 16'd2, cyc2);
      total++;
      if (cyc1 !== 5 || cyc2 !== 5) begin
         bad++;
         $display("FAIL b2b_latency: cycles %0d,%0d required 5,5", cyc1, cyc2);
      end
      total++;
      if (mem[widx(32'h1F0)] !== exp_mem[widx(32'h1F0)] || mem[widx(32'h1F4)] !== exp_mem[widx(32'h1F4)]) begin
         bad++;
         $display("FAIL b2b_data: got %h %h required %h %h", mem[widx(32'h1F0)], mem[widx(32'h1F4)],
                  exp_mem[widx(32'h1F0)], exp_mem[widx(32'h1F4)]);
      end
   endtask

`ifdef MEM_COPY_CHECKSUM_EN
   task automatic test_checksum();
      int cyc;
      mem[0] = 32'hA5A5A5A5;
      mem[1] = 32'h0F0F0F0F;
      run_copy(32'h0, 32'h40, 16'd2, cyc);
      repeat (3) @(negedge clk);
      total++;
      if (checksum !== 32'hAAAAAAAA) begin
         bad++;
         $display("FAIL checksum_value: got %h required aaaaaaaa", checksum);
      end
   endtask
`endif

   task automatic test_invariants();
      total++;
      if (both_total !== 0 || idle_bad !== 0) begin
         bad++;
         $display("FAIL invariants: read+write overlap=%0d idle nonzero=%0d required 0/0", both_total, idle_bad);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad = 0;
      both_total = 0;
      idle_bad = 0;
      done_cnt = 0;
      rst = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_basic();
      test_zero_length();
      test_start_while_busy();
      test_reset_mid_copy();
      test_misalign_wrap();
      test_overlap();
      test_random();
      test_back_to_back();
`ifdef MEM_COPY_CHECKSUM_EN
      test_checksum();
`endif
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the word-count input.
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning the byte stride per word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a copy request sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, 32, the source byte address.
REQ-007 SHALL have port dst_addr, input, 32, the destination byte address.
REQ-008 SHALL have port len, input, LEN_W, the number of words to copy.
REQ-009 SHALL have port memoryOutData, input, 32, the combinational read data returned by the memory.
REQ-010 SHALL have port memoryRead, output, 1, the read strobe.
REQ-011 SHALL have port memoryWrite, output, 1, the write strobe.
REQ-012 SHALL have port memoryAddress, output, 32, the byte address presented to the memory.
REQ-013 SHALL have port memoryWriteData, output, 32, the data to be written.
REQ-014 SHALL have port busy, output, 1, high while a copy is in progress.
REQ-015 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-016 SHALL have port words_done, output, LEN_W, the count of words written in the current or last copy.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-018 IDLE: when start=1, SHALL latch src_addr and dst_addr with bits [1:0] forced to 00, latch len, clear words_done, and go to DONE if len=0, else to READ.
REQ-019 READ: SHALL drive memoryRead=1 and memoryAddress=src pointer, capture memoryOutData into the data register at the clock edge, then go to WRITE.
REQ-020 WRITE: SHALL drive memoryWrite=1, memoryAddress=dst pointer, and memoryWriteData=data register; at the edge it SHALL add WORD_BYTES to both pointers, decrement remaining, and increment words_done.
REQ-021 WRITE: SHALL go to DONE when remaining was 1 before the decrement, else back to READ.
REQ-022 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-023 memoryRead and memoryWrite SHALL never be high in the same cycle, and SHALL both be 0 in IDLE and DONE.
REQ-024 memoryAddress and memoryWriteData SHALL be 0 in IDLE and DONE.
REQ-025 busy SHALL be high in READ, WRITE and DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Latency: for len=N>0, done SHALL be high exactly 2N+1 cycles after the start-sampling edge; for len=0, 1 cycle after it.
REQ-028 Pointer arithmetic SHALL be modulo 2^32, so 0xFFFFFFFC + 4 wraps to 0x00000000.
REQ-029 Overlapping source and destination regions SHALL be copied in ascending address order with no overlap correction.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE and clear pointers, remaining, the data register and words_done.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 rst asserted in READ or WRITE SHALL abort the copy; no write strobe shall occur in the cycle after the reset edge, and done shall not pulse.

Configuration
REQ-033 With macro MEM_COPY_CHECKSUM_EN defined, the block SHALL add output checksum (32 bits): cleared on an accepted start, XORed with each word written in WRITE, held after DONE, and 0 under reset.
REQ-034 Without MEM_COPY_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 Package mem_copy_pkg SHALL hold the FSM state typedef (IDLE, READ, WRITE, DONE) and the constant WORD_BYTES_DEFAULT=4.
REQ-036 The checksum accumulator SHALL be the single sub-module mem_copy_csum, instantiated only under MEM_COPY_CHECKSUM_EN.
REQ-037 All other logic SHALL reside in mem_copy_engine.

Verification
REQ-038 Basic copy: memory preloaded with words[0..3]=0x11,0x22,0x33,0x44; start with src=0x0, dst=0x40, len=4 -> words[16..19] equal 0x11..0x44, done pulses at cycle 9, and words_done=4.
REQ-039 Zero length: start with len=0 -> no read or write strobes, and done pulses 1 cycle after start.
REQ-040 Start while busy: a second start during a len=3 copy -> ignored; exactly 3 writes occur and done pulses once.
REQ-041 Reset mid-copy: rst asserted in the WRITE of word 2 of len=5 -> next cycle is IDLE with all outputs 0, only 1 or 2 destination words modified, and no done pulse.
REQ-042 Misalignment and wrap: src=0x3 -> first read address is 0x0; dst=0xFFFFFFFC with len=2 -> write addresses are 0xFFFFFFFC then 0x00000000.
REQ-043 Checksum (MEM_COPY_CHECKSUM_EN defined): copy of 0xA5A5A5A5, 0x0F0F0F0F -> checksum=0xAAAAAAAA after done.
